// File: rtl/operand_bank_arbiter_pkg.sv
// operand_bank_arbiter_pkg: shared operand-queue indices, types and default
// arbiter configuration for the VRF bank read-port arbiter.
package operand_bank_arbiter_pkg;

    localparam int unsigned NrOperandQueues = 9;
    localparam int unsigned DefQueueDepth   = 5;
    localparam int unsigned DefAddrWidth    = 8;
    localparam int unsigned ElenWidth       = 64;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(NrOperandQueues)-1:0] opq_idx_t;
    typedef logic [$clog2(DefQueueDepth + 1)-1:0]  credit_t;
    typedef logic [ElenWidth-1:0]                  elen_t;

    typedef enum opq_idx_t {
        AluA, AluB, MulFPUA, MulFPUB, MulFPUC, StA, SlideAddrGenA, MaskB, MaskM
    } opq_e;

    // ALU and MFPU operand fetches sit on the critical issue path
    localparam logic [NrOperandQueues-1:0] DefHiPrioMask = NrOperandQueues'(
        (1 << AluA) | (1 << AluB) | (1 << MulFPUA) | (1 << MulFPUB) | (1 << MulFPUC));

endpackage

// File: rtl/operand_bank_arbiter_rr_pick.sv
// operand_bank_arbiter_rr_pick: combinational round-robin picker; searches upward
// from ptr with wrap-around and returns a one-hot grant.
module operand_bank_arbiter_rr_pick #(
    parameter int unsigned N  = 9,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [N-1:0] upper, pool;

    // requests at or above the pointer take precedence; otherwise wrap to the bottom
    assign upper = req & ~((N'(1) << ptr) - N'(1));
    assign pool  = (upper != '0) ? upper : req;
    assign gnt   = pool & (~pool + N'(1));
    assign valid = req != '0;

endmodule

// File: rtl/operand_bank_arbiter.sv
// operand_bank_arbiter: credit-based two-class round-robin arbiter sharing one VRF bank
// read port among the operand queues. Define OPBANK_STARVE_EN to add starvation promotion.
module operand_bank_arbiter
    import operand_bank_arbiter_pkg::*;
#(
    parameter int unsigned      NrReq       = NrOperandQueues,
    parameter int unsigned      QueueDepth  = DefQueueDepth,
    parameter logic [NrReq-1:0] HiPrioMask  = DefHiPrioMask,
    parameter int unsigned      ReadLatency = 1,
    parameter int unsigned      AddrWidth   = DefAddrWidth,
    parameter int unsigned      StarveLimit = 16,
    localparam int unsigned     CW          = $clog2(QueueDepth + 1),
    localparam int unsigned     IW          = idx_width(NrReq)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NrReq-1:0]           req_i,
    input  logic [NrReq*AddrWidth-1:0] req_addr_i,
    output logic [NrReq-1:0]           gnt_o,
    output logic                       vrf_req_o,
    output logic [AddrWidth-1:0]       vrf_addr_o,
    input  logic [ElenWidth-1:0]       vrf_rdata_i,
    output logic [ElenWidth-1:0]       operand_o,
    output logic [NrReq-1:0]           operand_valid_o,
    input  logic [NrReq-1:0]           queue_pop_i,
    output logic [NrReq*CW-1:0]        credit_o
);

    logic [NrReq-1:0] elig, hi_req, lo_req, hi_gnt, lo_gnt;
    logic             hi_valid, lo_valid, hi_win;
    logic [IW-1:0]    hi_ptr, lo_ptr, win, win_next;
    logic             tag_v   [ReadLatency];
    logic [IW-1:0]    tag_idx [ReadLatency];

    if (ReadLatency < 1 || ReadLatency > 2 || StarveLimit < 1) begin : g_bad_cfg
        $error("operand_bank_arbiter: ReadLatency must be 1 or 2 and StarveLimit nonzero");
    end

    for (genvar i = 0; i < NrReq; i++) begin : g_req
        logic [CW-1:0] credit;
        logic          pop;
        // a pop into an already empty queue would overflow the credit count
        assign pop     = queue_pop_i[i] && (credit != CW'(QueueDepth));
        assign elig[i] = req_i[i] && (credit != '0);
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) credit <= CW'(QueueDepth);
            else if (gnt_o[i] && !pop) credit <= credit - CW'(1);
            else if (pop && !gnt_o[i]) credit <= credit + CW'(1);
        end
        assign credit_o[i*CW +: CW] = credit;
        assign operand_valid_o[i]   = tag_v[ReadLatency-1] && (tag_idx[ReadLatency-1] == IW'(i));
        a_no_pop_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(queue_pop_i[i] && credit == CW'(QueueDepth)));
    end

    assign hi_req = elig & HiPrioMask;
    assign lo_req = elig & ~HiPrioMask;

    operand_bank_arbiter_rr_pick #(.N(NrReq)) i_hi_pick (
        .req(hi_req), .ptr(hi_ptr), .gnt(hi_gnt), .valid(hi_valid)
    );

    operand_bank_arbiter_rr_pick #(.N(NrReq)) i_lo_pick (
        .req(lo_req), .ptr(lo_ptr), .gnt(lo_gnt), .valid(lo_valid)
    );

`ifdef OPBANK_STARVE_EN
    localparam int unsigned SW = $clog2(StarveLimit + 1);
    logic [NrReq-1:0] starved, starve_gnt;
    for (genvar i = 0; i < NrReq; i++) begin : g_starve
        if (HiPrioMask[i]) begin : g_hi
            assign starved[i] = 1'b0;
        end else begin : g_lo
            logic [SW-1:0] wait_cnt;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) wait_cnt <= '0;
                else if (gnt_o[i]) wait_cnt <= '0;
                else if (elig[i] && wait_cnt != SW'(StarveLimit)) wait_cnt <= wait_cnt + SW'(1);
            end
            assign starved[i] = elig[i] && (wait_cnt == SW'(StarveLimit));
        end
    end
    // promoted requesters outrank the regular high class, lowest index first
    assign starve_gnt = starved & (~starved + NrReq'(1));
    assign gnt_o      = (starved != '0) ? starve_gnt : hi_valid ? hi_gnt : lo_gnt;
    assign hi_win     = (starved != '0) || hi_valid;
`else
    assign gnt_o  = hi_valid ? hi_gnt : lo_gnt;
    assign hi_win = hi_valid;
`endif

    assign vrf_req_o = hi_valid || lo_valid;

    always_comb begin
        win        = '0;
        vrf_addr_o = '0;
        for (int i = 0; i < NrReq; i++) begin
            if (gnt_o[i]) begin
                win        = IW'(i);
                vrf_addr_o = req_addr_i[i*AddrWidth +: AddrWidth];
            end
        end
    end

    assign win_next  = (win == IW'(NrReq - 1)) ? '0 : win + IW'(1);
    assign operand_o = tag_v[ReadLatency-1] ? vrf_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_ptr <= '0;
            lo_ptr <= '0;
        end else if (vrf_req_o) begin
            if (hi_win) hi_ptr <= win_next;
            else lo_ptr <= win_next;
        end
    end

    // tag chain mirrors the bank pipeline so data lands in the queue that asked for it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < ReadLatency; s++) begin
                tag_v[s]   <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            tag_v[0]   <= vrf_req_o;
            tag_idx[0] <= win;
            for (int s = 1; s < ReadLatency; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

endmodule
